// File: rtl/handshake_pkg.sv
// Shared constants and helpers for the valid/ready pipeline slice.
package handshake_pkg;

  localparam int HS_BYPASS = 0;
  localparam int HS_FWD    = 1;
  localparam int HS_SKID   = 2;

  // Occupancy counter width able to hold 0 .. 2*stages.
  function automatic int hs_occ_w(input int stages);
    return $clog2(2 * stages + 1);
  endfunction

endpackage

// File: rtl/handshake_stage.sv
// One valid/ready register stage: FWD (1 entry, combinational ready) or
// SKID (main + skid entry, registered ready).
module handshake_stage
  import handshake_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int MODE       = HS_FWD
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [1:0]            cnt_o
);

  logic                  valid_q;
  logic [DATA_WIDTH-1:0] data_q;

  assign valid_o = valid_q;
  assign data_o  = data_q;

  if (MODE == HS_SKID) begin : g_skid
    logic                  skid_valid;
    logic [DATA_WIDTH-1:0] skid_data;

    assign ready_o = !skid_valid;
    assign cnt_o   = {1'b0, valid_q} + {1'b0, skid_valid};

    // skid_valid implies valid_q, so ready_i alone means main is draining.
    always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
        valid_q    <= 1'b0;
        skid_valid <= 1'b0;
      end else if (skid_valid) begin
        if (ready_i) begin
          valid_q    <= 1'b1;
          data_q     <= skid_data;
          skid_valid <= 1'b0;
        end
      end else if (!valid_q || ready_i) begin
        valid_q <= valid_i;
        if (valid_i) data_q <= data_i;
      end else if (valid_i) begin
        skid_valid <= 1'b1;
        skid_data  <= data_i;
      end
    end
  end else begin : g_fwd
    assign ready_o = !valid_q || ready_i;
    assign cnt_o   = {1'b0, valid_q};

    always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) valid_q <= 1'b0;
      else if (ready_o)     valid_q <= valid_i;
    end

    always_ff @(posedge clk_i) begin
      if (valid_i && ready_o) data_q <= data_i;
    end
  end

endmodule

// File: rtl/handshake_pipe.sv
// Chain of STAGES handshake stages (or pure wires in BYPASS) with flush
// and a beat-occupancy output.
module handshake_pipe
  import handshake_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int STAGES     = 1,
  parameter int MODE       = HS_FWD,
  parameter int OCC_W      = hs_occ_w(STAGES)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [OCC_W-1:0]      occ_o
);

  if (MODE == HS_BYPASS) begin : g_bypass
    logic unused_bypass;
    assign unused_bypass = ^{clk_i, rst_i, flush_i};
    assign data_o  = data_i;
    assign valid_o = valid_i;
    assign ready_o = ready_i;
    assign occ_o   = '0;
  end else if (MODE == HS_FWD || MODE == HS_SKID) begin : g_chain
    logic [DATA_WIDTH-1:0] data_s  [STAGES+1];
    logic                  valid_s [STAGES+1];
    logic [1:0]            cnt_s   [STAGES];
    logic [OCC_W-1:0]      occ_sum;

    assign data_s[0]  = data_i;
    assign valid_s[0] = valid_i;
    assign data_o     = data_s[STAGES];
    assign valid_o    = valid_s[STAGES];

    // Ready travels backwards through per-stage nets so the FWD chain
    // stays a plain combinational path rather than a self-referencing vector.
    for (genvar i = 0; i < STAGES; i++) begin : g_stage
      logic rdy;
      logic rdy_dn;

      if (i == STAGES - 1) begin : g_last
        assign rdy_dn = ready_i;
      end else begin : g_mid
        assign rdy_dn = g_stage[i+1].rdy;
      end

      handshake_stage #(
        .DATA_WIDTH(DATA_WIDTH),
        .MODE      (MODE)
      ) u_stage (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .flush_i(flush_i),
        .data_i (data_s[i]),
        .valid_i(valid_s[i]),
        .ready_o(rdy),
        .data_o (data_s[i+1]),
        .valid_o(valid_s[i+1]),
        .ready_i(rdy_dn),
        .cnt_o  (cnt_s[i])
      );
    end

    assign ready_o = g_stage[0].rdy;

    always_comb begin
      occ_sum = '0;
      for (int unsigned i = 0; i < STAGES; i++) begin
        occ_sum = occ_sum + OCC_W'(cnt_s[i]);
      end
    end

    assign occ_o = occ_sum;
  end else begin : g_bad_mode
    $error("handshake_pipe: MODE must be 0 (BYPASS), 1 (FWD) or 2 (SKID)");
  end

endmodule

// File: doc/handshake_pipe.md
# handshake_pipe

Parametrised valid/ready pipeline slice for cutting timing paths on streaming interfaces between core units, such as fetch→decode, LSU→cache and bus bridges. It is a chain of `STAGES` identical register stages. Each stage runs in one of three modes:

- **BYPASS**: pure wires.
- **FWD**: registered valid/data, combinational ready.
- **SKID**: fully registered, with both valid/data and ready cut.

Adds a synchronous flush and an occupancy output. This is the successor to the single-entry handshake register.

## Interface

Parameters:

- `DATA_WIDTH`, 64: payload width in bits (≥1).
- `STAGES`, 1: number of chained stages (≥1). Ignored in BYPASS.
- `MODE`, 1: 0 = BYPASS, 1 = FWD, 2 = SKID. Any other value is an elaboration error.
- `OCC_W`, `$clog2(2*STAGES+1)`: occupancy width. Derived; do not override.

Ports:

- `clk_i`, in, 1: clock. Everything is on the rising edge.
- `rst_i`, in, 1: reset, synchronous, active-high.
- `flush_i`, in, 1: synchronous flush; discards all held beats.
- `data_i`, in, DATA_WIDTH: upstream payload.
- `valid_i`, in, 1: upstream valid.
- `ready_o`, out, 1: upstream ready.
- `data_o`, out, DATA_WIDTH: downstream payload.
- `valid_o`, out, 1: downstream valid.
- `ready_i`, in, 1: downstream ready.
- `occ_o`, out, OCC_W: number of beats currently held, registered.

## Operation

- **Transfer rule.** A beat transfers on a port when valid & ready are both high at the clock edge. Once valid is asserted it must not drop, and data must stay stable, until the transfer completes. Both sides obey this.
- **Ordering.** Beats leave in acceptance order. None are duplicated or dropped, except by flush.

**BYPASS**
- `data_o = data_i`, `valid_o = valid_i`, `ready_o = ready_i`.
- `occ_o = 0`. No state.

**FWD stage** (1 entry)
- `ready_o = !valid_q | ready_i`.
- `valid_q` loads `valid_i` whenever `ready_o` is high.
- `data_q` loads only on an accepted beat.

**SKID stage** (2 entries: main + skid)
- `ready_o = !skid_valid`. This is a register output with no combinational path from `ready_i`.
- Accept while main is empty, or main is draining this cycle: the beat goes to main.
- Accept while main is full and stalled: the beat goes to skid.
- Main drains while skid is valid: main loads skid and skid clears.
- Steady streaming gives 1 beat/cycle, and skid is never used.

**Occupancy**
- `occ_o` is the registered sum of all valid bits in all stages.
- Updated as +1 on input accept, −1 on output transfer, 0 net when both happen.
- Maximum is STAGES in FWD and 2·STAGES in SKID.

**Flush** (highest priority below reset)
- On a cycle with `flush_i` = 1, the next state clears all valid bits and sets `occ_o` to 0.
- A beat accepted in the flush cycle is discarded.
- An output transfer in the flush cycle still counts as delivered. `valid_o` is registered, so the consumer legally took it.
- `ready_o` is not gated by flush.

**Reset**
- `valid_o` = 0, `occ_o` = 0, all internal valid bits = 0.
- SKID `ready_o` = 1 after reset; FWD `ready_o` = 1 after reset.
- Data registers are not reset; `data_o` is undefined while `valid_o` = 0.
- Reset mid-stream drops every held beat.

## Timing

- **Latency.** FWD and SKID: exactly STAGES cycles from input accept to `valid_o` when unstalled. BYPASS: 0.
- **Throughput.** 1 beat/cycle sustained in all modes.
- **FWD back-pressure.** `ready_o` follows `ready_i` combinationally, through the full chain when all stages are full.
- **SKID back-pressure.** `ready_o` deasserts 1 cycle after the first stall cycle, when the skid fills. It reasserts the cycle after a downstream transfer empties the skid.
- **Capacity.** SKID absorbs ≤2·STAGES beats under continuous stall; FWD absorbs ≤STAGES.
- **Simultaneous events.**
  - Accept and drain on a full FWD stage in the same cycle: the stage stays full and `occ_o` is unchanged.
  - Reset with flush: reset wins, with an identical result.

## Structure

- Sub-module `handshake_stage`: one stage with a MODE parameter (FWD/SKID) and `flush_i`. `handshake_pipe` generates the chain and sums the valid bits for `occ_o`.
- Shared package `handshake_pkg`:
  - mode constants `HS_BYPASS` = 0, `HS_FWD` = 1, `HS_SKID` = 2
  - helper function `hs_occ_w(stages)`

## Test plan

1. **Streaming.** MODE=2, STAGES=2, ready_i=1, 8 back-to-back beats 0..7.
   - Outputs 0..7 appear on consecutive cycles, first one 2 cycles after the first accept.
   - `ready_o` stays 1 and `occ_o` ≤ 2.
2. **Stall fill.** MODE=2, STAGES=1, ready_i=0, valid_i=1, beats A, B, C.
   - A and B are accepted; `ready_o` = 0 from cycle 2; C is held upstream; `occ_o` = 2.
   - Set ready_i=1: outputs are A, B, C in order.
3. **FWD stall.** MODE=1, STAGES=3, ready_i=0, 5 beats offered.
   - Exactly 3 are accepted, `occ_o` = 3, and `ready_o` = 0 combinationally.
   - ready_i=1 for 1 cycle: `ready_o` = 1 in that same cycle.
4. **Flush.** MODE=2, STAGES=2, with 4 beats held.
   - Pulse `flush_i` while valid_i=1 with beat 0xAA.
   - Next cycle `valid_o` = 0 and `occ_o` = 0. 0xAA never appears on the output.
5. **Reset mid-stream.** MODE=1, with 2 beats held.
   - Assert rst_i for 1 cycle: `valid_o` = 0 and `occ_o` = 0 next cycle, and the next new beat is the first one out.
6. **BYPASS.** MODE=0, random valid/ready.
   - Outputs equal inputs in the same cycle and `occ_o` = 0 throughout.
